// File: rtl/cmsdk_fpga_sram_init_pkg.sv
// Shared types and helpers for the parametrised FPGA SRAM with clear engine.
// Optional per-lane parity is enabled by defining CMSDK_FPGA_SRAM_PARITY_EN.
package cmsdk_fpga_sram_init_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sram_state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  function automatic bit rd_pipe_legal(input int p);
    return (p == 1) || (p == 2);
  endfunction

endpackage

// File: rtl/cmsdk_fpga_sram_init_lane.sv
// One 8-bit block-RAM lane with write enable and registered read.
// With CMSDK_FPGA_SRAM_PARITY_EN defined each word carries an even-parity bit.
module cmsdk_fpga_sram_init_lane
  import cmsdk_fpga_sram_init_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          inj,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata,
  output logic          perr
);

`ifdef CMSDK_FPGA_SRAM_PARITY_EN
  logic [8:0] mem [2**AW];
  logic [8:0] rd_reg;

  // inj flips the stored parity so the next read of this lane mismatches
  always_ff @(posedge CLK) begin
    if (we)
      mem[waddr] <= {even_parity(wdata) ^ inj, wdata};
    if (re)
      rd_reg <= mem[raddr];
  end

  assign rdata = rd_reg[7:0];
  assign perr  = rd_reg[8] ^ even_parity(rd_reg[7:0]);
`else
  logic [7:0] mem [2**AW];
  logic [7:0] rd_reg;
  logic       unused_inj;

  always_ff @(posedge CLK) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rd_reg <= mem[raddr];
  end

  assign unused_inj = inj;
  assign rdata      = rd_reg;
  assign perr       = 1'b0;
`endif

endmodule

// File: rtl/cmsdk_fpga_sram_init.sv
// Byte-lane SRAM with hardware clear engine (BUSY), read-valid strobe and 1/2-stage read pipe.
// Define CMSDK_FPGA_SRAM_PARITY_EN to add per-lane parity storage and the PERR flag.
module cmsdk_fpga_sram_init
  import cmsdk_fpga_sram_init_pkg::*;
#(
  parameter int         AW            = 14,
  parameter int         DW            = 32,
  parameter int         RD_PIPE       = 1,
  parameter int         INIT_ON_RESET = 1,
  parameter logic [7:0] INIT_VALUE    = 8'h00
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            CS,
  input  logic [AW-1:0]   ADDR,
  input  logic [DW-1:0]   WDATA,
  input  logic [DW/8-1:0] WREN,
  input  logic            CLR,
  input  logic            PERR_INJ,
  output logic [DW-1:0]   RDATA,
  output logic            RVALID,
  output logic            BUSY,
  output logic            PERR
);

  localparam int NB = DW / 8;

  generate
    if (!rd_pipe_legal(RD_PIPE) || (DW % 8 != 0)) begin : g_bad_cfg
      $error("cmsdk_fpga_sram_init: RD_PIPE must be 1 or 2 and DW a multiple of 8");
    end
  endgenerate

  sram_state_t   state_reg;
  logic [AW-1:0] cnt_reg;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (CLR)
            cnt_reg <= '0;
          else if (cnt_reg == {AW{1'b1}}) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
          end else
            cnt_reg <= cnt_reg + 1'b1;
        end
        default: begin
          if (CLR) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
          end
        end
      endcase
    end
  end

  logic run, acc_wr, acc_rd;
  assign run    = (state_reg == ST_RUN);
  assign acc_wr = run & CS & (|WREN);
  assign acc_rd = run & CS & ~(|WREN);
  assign BUSY   = ~run;

  // During INIT the clear engine owns the write port and all lanes
  logic [AW-1:0] waddr_mux;
  logic [DW-1:0] wdata_mux;
  logic [NB-1:0] lane_we;
  logic          inj_mux;
  assign waddr_mux = run ? ADDR : cnt_reg;
  assign wdata_mux = run ? WDATA : {NB{INIT_VALUE}};
  assign lane_we   = run ? (acc_wr ? WREN : '0) : '1;
  assign inj_mux   = run & PERR_INJ;

  logic [DW-1:0] lane_rdata;
  logic [NB-1:0] lane_perr;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      cmsdk_fpga_sram_init_lane #(.AW(AW)) u_lane (
        .CLK   (CLK),
        .we    (lane_we[gi]),
        .waddr (waddr_mux),
        .wdata (wdata_mux[8*gi +: 8]),
        .inj   (inj_mux),
        .re    (acc_rd),
        .raddr (ADDR),
        .rdata (lane_rdata[8*gi +: 8]),
        .perr  (lane_perr[gi])
      );
    end
  endgenerate

  logic          rv1_reg;
  logic [DW-1:0] d1;
  logic          p1;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      rv1_reg <= 1'b0;
    else
      rv1_reg <= acc_rd;
  end

  // Gate the BRAM output so data reads as zero whenever no response is due
  assign d1 = rv1_reg ? lane_rdata : '0;
  assign p1 = rv1_reg & (|lane_perr);

  generate
    if (RD_PIPE == 2) begin : g_pipe2
      logic          rv2_reg;
      logic [DW-1:0] d2_reg;
      logic          p2_reg;

      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          rv2_reg <= 1'b0;
          d2_reg  <= '0;
          p2_reg  <= 1'b0;
        end else begin
          rv2_reg <= rv1_reg;
          d2_reg  <= d1;
          p2_reg  <= p1;
        end
      end

      assign RVALID = rv2_reg;
      assign RDATA  = d2_reg;
      assign PERR   = p2_reg;
    end else begin : g_pipe1
      assign RVALID = rv1_reg;
      assign RDATA  = d1;
      assign PERR   = p1;
    end
  endgenerate

endmodule

// File: tb/tb_cmsdk_fpga_sram_init.sv
// Directed bench: dut1 (AW=4, DW=32, RD_PIPE=1, fill A5) and dut2 (AW=6, DW=64, RD_PIPE=2, fill 3C).
module tb_cmsdk_fpga_sram_init;

`ifdef CMSDK_FPGA_SRAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cs1 = 0, clr1 = 0, inj1 = 0;
  logic [3:0]  addr1 = '0, wren1 = '0;
  logic [31:0] wdata1 = '0, rdata1;
  logic        rvalid1, busy1, perr1;

  logic        cs2 = 0, clr2 = 0, inj2 = 0;
  logic [5:0]  addr2 = '0;
  logic [7:0]  wren2 = '0;
  logic [63:0] wdata2 = '0, rdata2;
  logic        rvalid2, busy2, perr2;

  cmsdk_fpga_sram_init #(.AW(4), .DW(32), .RD_PIPE(1), .INIT_ON_RESET(1), .INIT_VALUE(8'hA5)) dut1 (
    .CLK(clk), .RESETn(rst_n), .CS(cs1), .ADDR(addr1), .WDATA(wdata1), .WREN(wren1),
    .CLR(clr1), .PERR_INJ(inj1), .RDATA(rdata1), .RVALID(rvalid1), .BUSY(busy1), .PERR(perr1));

  cmsdk_fpga_sram_init #(.AW(6), .DW(64), .RD_PIPE(2), .INIT_ON_RESET(1), .INIT_VALUE(8'h3C)) dut2 (
    .CLK(clk), .RESETn(rst_n), .CS(cs2), .ADDR(addr2), .WDATA(wdata2), .WREN(wren2),
    .CLR(clr2), .PERR_INJ(inj2), .RDATA(rdata2), .RVALID(rvalid2), .BUSY(busy2), .PERR(perr2));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until each BUSY drops; -1 means the bound expired
  task automatic count_busy(output int n1, output int n2);
    n1 = -1;
    n2 = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (n1 < 0 && !busy1) n1 = c;
      if (n2 < 0 && !busy2) n2 = c;
      if (n1 >= 0 && n2 >= 0) break;
    end
  endtask

  task automatic wr1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we, input logic inj);
    $display("dut1 wr addr=%0d data=%h wren=%b inj=%b", a, d, we, inj);
    cs1 = 1; addr1 = a; wdata1 = d; wren1 = we; inj1 = inj;
    tick();
    cs1 = 0; wren1 = '0; inj1 = 0;
  endtask

  task automatic rd1(input logic [3:0] a, input logic [31:0] exp, input logic exp_perr);
    cs1 = 1; addr1 = a; wren1 = '0;
    tick();
    cs1 = 0;
    $display("dut1 rd addr=%0d data=%h rvalid=%b perr=%b", a, rdata1, rvalid1, perr1);
    check("rd1_valid", rvalid1, 1'b1);
    check("rd1_data", rdata1, exp);
    check("rd1_perr", perr1, exp_perr);
  endtask

  task automatic rd2(input logic [5:0] a, input logic [63:0] exp);
    cs2 = 1; addr2 = a; wren2 = '0;
    tick();
    cs2 = 0;
    check("rd2_gap_valid", rvalid2, 1'b0);
    check("rd2_gap_data", rdata2, 64'h0);
    tick();
    $display("dut2 rd addr=%0d data=%h rvalid=%b", a, rdata2, rvalid2);
    check("rd2_valid", rvalid2, 1'b1);
    check("rd2_data", rdata2, exp);
  endtask

  initial begin
    int n1, n2, rv_cnt, nb;

    // Reset state
    #1;
    check("rst_busy1", busy1, 1'b1);
    check("rst_rvalid1", rvalid1, 1'b0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_perr1", perr1, 1'b0);
    check("rst_busy2", busy2, 1'b1);
    check("rst_rdata2", rdata2, 64'h0);
    tick();
    rst_n = 1;

    // Clear after reset lasts exactly 2**AW cycles
    count_busy(n1, n2);
    $display("init done dut1_cycles=%0d dut2_cycles=%0d", n1, n2);
    check("init_len1", n1, 16);
    check("init_len2", n2, 64);

    // Back-to-back reads of the whole dut1 array
    cs1 = 1; wren1 = '0;
    for (int a = 0; a < 16; a++) begin
      addr1 = a[3:0];
      tick();
      check("fill_valid", rvalid1, 1'b1);
      check("fill_data", rdata1, 32'hA5A5A5A5);
    end
    cs1 = 0;
    tick();
    check("idle_valid1", rvalid1, 1'b0);
    check("idle_data1", rdata1, 32'h0);

    // Partial-lane write, then immediate read-back
    wr1(4'd3, 32'h12345678, 4'b0101, 1'b0);
    rd1(4'd3, 32'hA534A578, 1'b0);
    wr1(4'd7, 32'hCAFEF00D, 4'b1111, 1'b0);
    rd1(4'd7, 32'hCAFEF00D, 1'b0);
    wr1(4'd9, 32'h11223344, 4'b1000, 1'b0);
    rd1(4'd9, 32'h11A5A5A5, 1'b0);

    // Parity injection on lane 1 of address 2
    wr1(4'd2, 32'h0000AB00, 4'b0010, 1'b1);
    rd1(4'd2, 32'hA5A5ABA5, PAR_EN);
    rd1(4'd5, 32'hA5A5A5A5, 1'b0);

    // dut2: 64-bit write then back-to-back reads 3,4,3 through the 2-stage pipe
    $display("dut2 wr addr=3 data=1122334455667788 wren=01010101");
    cs2 = 1; addr2 = 6'd3; wdata2 = 64'h1122334455667788; wren2 = 8'h55;
    tick();
    wren2 = '0;
    tick();
    check("p2_lat_valid", rvalid2, 1'b0);
    check("p2_lat_data", rdata2, 64'h0);
    addr2 = 6'd4;
    tick();
    check("p2_r0_valid", rvalid2, 1'b1);
    check("p2_r0_data", rdata2, 64'h3C223C443C663C88);
    addr2 = 6'd3;
    tick();
    check("p2_r1_valid", rvalid2, 1'b1);
    check("p2_r1_data", rdata2, 64'h3C3C3C3C3C3C3C3C);
    cs2 = 0;
    tick();
    check("p2_r2_valid", rvalid2, 1'b1);
    check("p2_r2_data", rdata2, 64'h3C223C443C663C88);
    tick();
    check("p2_end_valid", rvalid2, 1'b0);
    check("p2_end_data", rdata2, 64'h0);

    // CLR coincident with a read: the read completes, then INIT ignores all accesses
    cs1 = 1; addr1 = 4'd3; wren1 = '0; clr1 = 1;
    tick();
    clr1 = 0;
    $display("dut1 clr with rd addr=3 data=%h rvalid=%b busy=%b", rdata1, rvalid1, busy1);
    check("clr_busy", busy1, 1'b1);
    check("clr_rd_valid", rvalid1, 1'b1);
    check("clr_rd_data", rdata1, 32'hA534A578);
    rv_cnt = 0;
    nb = -1;
    for (int c = 1; c <= 100; c++) begin
      cs1 = 1; addr1 = c[3:0]; wdata1 = 32'hDEADBEEF; wren1 = c[0] ? 4'hF : 4'h0;
      tick();
      if (rvalid1) rv_cnt++;
      if (!busy1) begin
        nb = c;
        break;
      end
    end
    cs1 = 0; wren1 = '0;
    check("clr_len", nb, 16);
    check("clr_no_rvalid", rv_cnt, 0);
    for (int a = 0; a < 16; a++)
      rd1(a[3:0], 32'hA5A5A5A5, 1'b0);

    // Reset asserted mid-INIT at counter 7 while dut2 has a read response out
    clr1 = 1;
    cs2 = 1; addr2 = 6'd4; wren2 = '0;
    tick();
    clr1 = 0;
    for (int c = 0; c < 7; c++) tick();
    check("pre_rst_busy1", busy1, 1'b1);
    check("pre_rst_valid2", rvalid2, 1'b1);
    check("pre_rst_data2", rdata2, 64'h3C3C3C3C3C3C3C3C);
    #3;
    rst_n = 0;
    #1;
    $display("async reset busy1=%b rvalid2=%b rdata2=%h", busy1, rvalid2, rdata2);
    check("arst_busy1", busy1, 1'b1);
    check("arst_valid1", rvalid1, 1'b0);
    check("arst_data1", rdata1, 32'h0);
    check("arst_valid2", rvalid2, 1'b0);
    check("arst_data2", rdata2, 64'h0);
    cs2 = 0;
    tick();
    tick();
    rst_n = 1;
    count_busy(n1, n2);
    $display("re-init done dut1_cycles=%0d dut2_cycles=%0d", n1, n2);
    check("reinit_len1", n1, 16);
    check("reinit_len2", n2, 64);
    rd1(4'd7, 32'hA5A5A5A5, 1'b0);
    rd2(6'd3, 64'h3C3C3C3C3C3C3C3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
